blink_period_meter: RTL and testbench
=====================================

# blink_period_meter

Receive-side companion to the LED blinker: it samples a toggling 1-bit line, such as a blinker output looped back or an external square wave. It measures the number of `CLOCK_50` cycles between successive transitions and reports each measurement with a one-cycle valid strobe. If no transition arrives within a configurable window, it flags the line as stalled. It sits next to the blinker in the top level and checks blink rate in hardware and in simulation.

## Interface
- `CNT_W`, 33: width of the interval counter and the measurement outputs.
- `TIMEOUT`, 20000: cycles without a transition before `stalled` asserts; must be ≥ 2 and < 2^CNT_W.

- `CLOCK_50` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sig_in` input 1: monitored line, asynchronous to `CLOCK_50`.
- `level` output 1: synchronized copy of `sig_in`.
- `half_period` output CNT_W: last measured interval between transitions, in cycles.
- `valid` output 1: one-cycle strobe; `half_period` updated this cycle.
- `stalled` output 1: no transition for `TIMEOUT` cycles.
- `min_period` output CNT_W: smallest `half_period` since reset (see Configuration).
- `max_period` output CNT_W: largest `half_period` since reset (see Configuration).

## Operation
- Synchronizer: two flops `s1`, `s2`, then a history flop `s3`. `edge = s2 ^ s3`. `level = s2`.
- Interval counter `cnt`, CNT_W bits:
  - Cleared to 0 on an edge cycle.
  - Otherwise increments, saturating at `TIMEOUT-1`.
- `armed` flag: set by any edge; cleared by reset and by timeout.
- Edge while `armed=1`: `half_period <= cnt+1`, `valid <= 1` for one cycle, `cnt <= 0`.
- Edge while `armed=0` (first edge after reset or after a stall): `armed <= 1`, `cnt <= 0`, `stalled <= 0`; no `valid`, and `half_period` is unchanged.
- Timeout: when `cnt == TIMEOUT-1` and there is no edge, then `stalled <= 1` and `armed <= 0`. Both hold until the next edge.
- Edge and timeout in the same cycle: the edge wins. The measurement is `cnt+1 = TIMEOUT`, `valid` asserts and `stalled` stays 0.
- States, implicit in `armed`/`stalled`:
  - IDLE (0/0) --edge--> ARMED (1/0).
  - ARMED --edge--> ARMED, emitting a measurement.
  - ARMED --timeout--> STALLED (0/1).
  - STALLED --edge--> ARMED, with no measurement.
  - IDLE --timeout--> STALLED.
- Arithmetic: `cnt+1` is computed in CNT_W bits and cannot overflow because `TIMEOUT < 2^CNT_W`.

## Timing
- Reset values: `s1`=`s2`=`s3`=0, `level`=0, `half_period`=0, `valid`=0, `stalled`=0, `min_period`=all-ones, `max_period`=0, `cnt`=0, `armed`=0.
- Reset asserted mid-measurement: all state returns to reset values on that edge. The next transition after release only re-arms.
- Latency: `sig_in` first sampled in its new state at clock edge k sets `s1` at k, `s2` at k+1, and the edge is seen in cycle k+1..k+2. `valid`/`half_period` register at edge k+2, so they are visible in the cycle after edge k+2.
- Throughput: one measurement per transition. Minimum measurable interval is 1 cycle, i.e. a transition on consecutive synchronized samples.
- `valid` is never high for two consecutive cycles unless `sig_in` toggles every cycle.

## Configuration
- `BLINK_METER_MINMAX_EN`:
  - Defined: on every `valid`, `min_period <= min(min_period, new value)` and `max_period <= max(max_period, new value)`, updated in the same cycle as `half_period`.
  - Undefined: `min_period` is tied to all-ones and `max_period` is tied to 0, with no tracking logic. The ports remain present.

## Test plan
- Reset, then `sig_in` toggling every 5001 cycles:
  - The first transition produces no `valid`.
  - Each later transition gives `half_period`=5001 with a one-cycle `valid`.
  - `stalled` stays 0.
- `sig_in` held constant for 25000 cycles with TIMEOUT=20000: `stalled`=1 at cycle 20000 after the last edge. The next toggle clears `stalled` with no `valid`. The following toggle after 100 cycles gives `half_period`=100.
- Transition arriving exactly at the timeout cycle (interval 20000): `valid`=1, `half_period`=20000, `stalled`=0.
- `reset` pulsed 1 cycle midway through a 5001-cycle interval: all outputs return to reset values. The next toggle produces no `valid`. The toggle after that reports the true interval.
- Intervals 300, 50, 900 with `BLINK_METER_MINMAX_EN` defined:
  - The first interval only arms, so a leading extra toggle is sent.
  - Ends with `min_period`=50 and `max_period`=900.
  - Without the macro, the same stimulus gives all-ones/0.
- `sig_in` toggling every cycle: `valid` is continuously high and `half_period`=1.

Source files
------------

// File: rtl/blink_period_meter.sv
// blink_period_meter: counts CLOCK_50 cycles between sig_in transitions and flags a stalled line.
// Latency: valid/half_period register two clocks after sig_in is first sampled high/low; output-only strobe, no backpressure.
// Optional min/max interval tracking is compiled in with BLINK_METER_MINMAX_EN.
module blink_period_meter #(
    parameter int CNT_W   = 33,
    parameter int TIMEOUT = 20000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             sig_in,
    output logic             level,
    output logic [CNT_W-1:0] half_period,
    output logic             valid,
    output logic             stalled,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             toggle;
    logic             timeout;
    logic [CNT_W-1:0] next_period;

    assign toggle      = s2 ^ s3;
    assign timeout     = (cnt == CNT_LAST) && !toggle;
    assign next_period = cnt + CNT_ONE;
    assign level       = s2;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            cnt         <= '0;
            armed       <= 1'b0;
            stalled     <= 1'b0;
            valid       <= 1'b0;
            half_period <= '0;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;
            if (toggle) begin
                // The first edge after reset or a stall has no start point, so it only arms.
                cnt     <= '0;
                armed   <= 1'b1;
                stalled <= 1'b0;
                if (armed) begin
                    half_period <= next_period;
                    valid       <= 1'b1;
                end
            end else if (timeout) begin
                // cnt stays saturated here until the next edge.
                stalled <= 1'b1;
                armed   <= 1'b0;
            end else begin
                cnt <= next_period;
            end
        end
    end

`ifdef BLINK_METER_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else if (toggle && armed) begin
            if (next_period < min_q) begin
                min_q <= next_period;
            end
            if (next_period > max_q) begin
                max_q <= next_period;
            end
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`else
    assign min_period = '1;
    assign max_period = '0;
`endif

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter with a timestamp-based reference model checked every cycle.
module tb_blink_period_meter;
    localparam int CNT_W   = 33;
    localparam int TIMEOUT = 20000;

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic             sig_in;
    logic             level;
    logic             valid;
    logic             stalled;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;

    int total = 0;
    int bad   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    blink_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .sig_in      (sig_in),
        .level       (level),
        .half_period (half_period),
        .valid       (valid),
        .stalled     (stalled),
        .min_period  (min_period),
        .max_period  (max_period)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the line as seen two samples late, and the time since the last
    // edge or reset expressed as a cycle-stamp difference.
    longint           t = 0;
    longint           ref_t = 0;
    longint           elapsed;
    logic [2:0]       hist;
    logic             tgl;
    logic             m_live = 1'b0;
    logic             m_armed;
    logic             m_stall;
    logic             m_valid;
    logic [CNT_W-1:0] m_hp;
    logic [CNT_W-1:0] m_min;
    logic [CNT_W-1:0] m_max;

    always @(posedge CLOCK_50) begin
        t = t + 1;
        if (reset) begin
            hist    = '0;
            ref_t   = t;
            m_armed = 1'b0;
            m_stall = 1'b0;
            m_valid = 1'b0;
            m_hp    = '0;
            m_min   = '1;
            m_max   = '0;
            m_live  = 1'b1;
        end else begin
            tgl     = hist[1] ^ hist[2];
            hist    = {hist[1:0], sig_in};
            elapsed = t - ref_t;
            m_valid = 1'b0;
            if (tgl) begin
                if (m_armed) begin
                    m_hp    = CNT_W'(elapsed);
                    m_valid = 1'b1;
                    if (m_hp < m_min) m_min = m_hp;
                    if (m_hp > m_max) m_max = m_hp;
                end
                m_armed = 1'b1;
                m_stall = 1'b0;
                ref_t   = t;
            end else if (elapsed >= TIMEOUT) begin
                m_stall = 1'b1;
                m_armed = 1'b0;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (m_live) begin
            chk("cyc_level", level, hist[1]);
            chk("cyc_valid", valid, m_valid);
            chk("cyc_half_period", half_period, m_hp);
            chk("cyc_stalled", stalled, m_stall);
`ifdef BLINK_METER_MINMAX_EN
            chk("cyc_min", min_period, m_min);
            chk("cyc_max", max_period, m_max);
`else
            chk("cyc_min", min_period, {CNT_W{1'b1}});
            chk("cyc_max", max_period, '0);
`endif
        end
    end

    // Toggle, check the strobe three samples later, then idle out the rest of the gap.
    task automatic pulse(input int gap, input bit exp_v, input int exp_hp);
        sig_in = ~sig_in;
        repeat (3) @(negedge CLOCK_50);
        chk("pulse_valid", valid, exp_v);
        chk("pulse_stalled", stalled, 0);
        if (exp_v) begin
            chk("pulse_hp", half_period, exp_hp);
            chk("model_hp", m_hp, exp_hp);
        end
        @(negedge CLOCK_50);
        chk("strobe_len", valid, 0);
        repeat (gap - 4) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        sig_in = 1'b0;
        @(negedge CLOCK_50);
        reset  = 1'b0;
        chk("rst_hp", half_period, 0);
        chk("rst_valid", valid, 0);
        chk("rst_stalled", stalled, 0);
        chk("rst_level", level, 0);
        chk("rst_min", min_period, 64'h1_FFFF_FFFF);
        chk("rst_max", max_period, 0);
        repeat (5) @(negedge CLOCK_50);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        do_reset();

        // Steady 5001-cycle half period, then one interval landing exactly on the timeout.
        pulse(5001, 1'b0, 0);
        pulse(5001, 1'b1, 5001);
        pulse(20000, 1'b1, 5001);
        pulse(4, 1'b1, 20000);

        // Line held: stalled must rise 20000 cycles after the edge seen at the third sample.
        n = 4;
        while (!stalled && n < 30000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("stall_delay", n, 20003);
        repeat (25000 - n) @(negedge CLOCK_50);
        chk("stall_hold", stalled, 1);
        pulse(100, 1'b0, 0);
        pulse(5001, 1'b1, 100);
        pulse(2500, 1'b1, 5001);

        // Reset midway through an interval; the next edge only re-arms.
        do_reset();
        pulse(5001, 1'b0, 0);
        pulse(10, 1'b1, 5001);

        do_reset();
        pulse(300, 1'b0, 0);
        pulse(50, 1'b1, 300);
        pulse(900, 1'b1, 50);
        pulse(10, 1'b1, 900);
`ifdef BLINK_METER_MINMAX_EN
        chk("final_min", min_period, 50);
        chk("final_max", max_period, 900);
`else
        chk("final_min", min_period, 64'h1_FFFF_FFFF);
        chk("final_max", max_period, 0);
`endif

        // Toggle every cycle: after the pipeline fills, valid stays high with a 1-cycle interval.
        for (int k = 0; k < 20; k++) begin
            sig_in = ~sig_in;
            @(negedge CLOCK_50);
            if (k >= 3) begin
                chk("fast_valid", valid, 1);
                chk("fast_hp", half_period, 1);
            end
        end
        repeat (5) @(negedge CLOCK_50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
